// File: rtl/mac_driver.sv
// Dot-product sequencer: streams len operand pairs from memory into an external
// 2-cycle multiplier and accumulates the signed products into a wrapping accumulator.
module mac_driver #(
  parameter int BITS     = 8,
  parameter int LEN_W    = 8,
  parameter int ACC_BITS = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [LEN_W-1:0]           len,
  output logic                       rd_en,
  output logic [LEN_W-1:0]           rd_addr,
  input  logic signed [BITS-1:0]     rd_a,
  input  logic signed [BITS-1:0]     rd_b,
  output logic                       mac_enable,
  output logic signed [BITS-1:0]     mac_a,
  output logic signed [BITS-1:0]     mac_b,
  input  logic signed [2*BITS-1:0]   mac_result,
  input  logic                       mac_done,
  output logic                       busy,
  output logic [ACC_BITS-1:0]        acc_out,
  output logic                       acc_valid,
  output logic                       overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]    done_cnt_q, done_cnt_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                mac_en_q, mac_en_d;
  logic [ACC_BITS-1:0] prod_ext_s;
  logic [ACC_BITS-1:0] sum_s;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  function automatic logic add_ovf(input logic [ACC_BITS-1:0] a,
                                   input logic [ACC_BITS-1:0] b,
                                   input logic [ACC_BITS-1:0] s);
    return (a[ACC_BITS-1] == b[ACC_BITS-1]) && (s[ACC_BITS-1] != a[ACC_BITS-1]);
  endfunction

  assign prod_ext_s = ACC_BITS'($signed(mac_result));
  assign sum_s      = acc_q + prod_ext_s;

  // Next-state, counters and accumulator.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    done_cnt_d  = done_cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    mac_en_d    = (state_q == ISSUE);

    if (mac_done && (state_q != IDLE)) begin
      acc_d      = sum_s;
      done_cnt_d = done_cnt_q + LEN_W'(1);
      if (add_ovf(acc_q, prod_ext_s, sum_s)) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d       = len;
          issue_cnt_d = '0;
          done_cnt_d  = '0;
          acc_d       = '0;
          ovf_d       = 1'b0;
          state_d     = (len == '0) ? FINISH : ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + LEN_W'(1);
        // Compare against the updated done count so FINISH lands the cycle after the last done.
        if (done_cnt_d == len_q) begin
          state_d = FINISH;
        end else if (issue_cnt_q == len_q - LEN_W'(1)) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (done_cnt_d == len_q) begin
          state_d = FINISH;
        end else begin
          state_d = DRAIN;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      mac_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      done_cnt_q  <= done_cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      mac_en_q    <= mac_en_d;
    end
  end

  assign rd_en      = (state_q == ISSUE);
  assign rd_addr    = issue_cnt_q;
  assign mac_enable = mac_en_q;
  // Operands pass straight through, forced to zero while reset is asserted.
  assign mac_a      = rst_n ? rd_a : '0;
  assign mac_b      = rst_n ? rd_b : '0;
  assign busy       = (state_q != IDLE);
  assign acc_valid  = (state_q == FINISH);
  assign acc_out    = acc_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mac_driver.sv
// Directed bench for mac_driver: operand memory and a 2-cycle multiplier are modelled
// here; a second instance with a 16-bit accumulator exercises overflow.
module tb_mac_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               start;
  logic [7:0]         len;
  logic               rd_en;
  logic [7:0]         rd_addr;
  logic signed [7:0]  rd_a, rd_b;
  logic               mac_enable;
  logic signed [7:0]  mac_a, mac_b;
  logic signed [15:0] mac_result;
  logic               mac_done;
  logic               busy;
  logic [23:0]        acc_out;
  logic               acc_valid;
  logic               overflow;

  logic signed [7:0]  mem_a [0:7];
  logic signed [7:0]  mem_b [0:7];
  logic signed [15:0] p1 = 16'sd0, p2 = 16'sd0;
  logic               v1 = 1'b0, v2 = 1'b0;
  logic               inj_done = 1'b0;
  logic signed [15:0] inj_res = 16'sd0;

  logic               start2;
  logic [7:0]         len2;
  logic               rd_en2;
  logic [7:0]         rd_addr2;
  logic signed [7:0]  mac_a2, mac_b2;
  logic               mac_enable2;
  logic               q1 = 1'b0, q2 = 1'b0;
  logic               busy2;
  logic [15:0]        acc_out2;
  logic               acc_valid2;
  logic               overflow2;

  integer n_vec = 0;
  integer n_err = 0;

  mac_driver #(.BITS(8), .LEN_W(8), .ACC_BITS(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
    .mac_enable(mac_enable), .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(mac_result), .mac_done(mac_done),
    .busy(busy), .acc_out(acc_out), .acc_valid(acc_valid), .overflow(overflow)
  );

  mac_driver #(.BITS(8), .LEN_W(8), .ACC_BITS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start2), .len(len2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_a(-8'sd128), .rd_b(-8'sd128),
    .mac_enable(mac_enable2), .mac_a(mac_a2), .mac_b(mac_b2),
    .mac_result(16'sd16384), .mac_done(q2),
    .busy(busy2), .acc_out(acc_out2), .acc_valid(acc_valid2), .overflow(overflow2)
  );

  // Operand memory with one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= mem_a[rd_addr[2:0]];
      rd_b <= mem_b[rd_addr[2:0]];
    end
  end

  // Two-stage multiplier models, enable to done in 2 cycles.
  always @(posedge clk) begin
    v1 <= mac_enable;
    p1 <= 16'(mac_a) * 16'(mac_b);
    v2 <= v1;
    p2 <= p1;
    q1 <= mac_enable2;
    q2 <= q1;
  end

  assign mac_done   = v2 | inj_done;
  assign mac_result = inj_done ? inj_res : p2;

  task automatic check_eq(input string tag, input integer got, input integer exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, ".rd_en"}, rd_en, 0);
    check_eq({tag, ".mac_enable"}, mac_enable, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".acc_valid"}, acc_valid, 0);
    check_eq({tag, ".overflow"}, overflow, 0);
    check_eq({tag, ".acc_out"}, acc_out, 0);
    check_eq({tag, ".rd_addr"}, rd_addr, 0);
    check_eq({tag, ".mac_a"}, $signed(mac_a), 0);
    check_eq({tag, ".mac_b"}, $signed(mac_b), 0);
  endtask

  task automatic set_ops(input integer i, input integer a, input integer b);
    mem_a[i] = 8'(a);
    mem_b[i] = 8'(b);
  endtask

  // Runs one dot product; start is high in cycle 0 and outputs are sampled mid-cycle.
  task automatic run_vec(input string tag, input integer n, input integer exp_acc,
                         input integer exp_ovf, input integer restart_cyc);
    integer first_v, nv, nrd, nme, first_rd, first_me, busy_low, addr_err, ovf_seen, busy_hi_to;
    logic [23:0] acc_seen;
    first_v = -1; nv = 0; nrd = 0; nme = 0; first_rd = -1; first_me = -1;
    busy_low = 0; addr_err = 0; ovf_seen = -1; acc_seen = 24'hx;
    busy_hi_to = (n == 0) ? 1 : n + 4;
    @(negedge clk);
    start = 1'b1;
    len   = 8'(n);
    for (int c = 1; c <= n + 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        len   = 8'hFF;
      end
      if (rd_en) begin
        nrd++;
        if (first_rd < 0) first_rd = c;
        if (rd_addr != 8'(c - 1)) addr_err++;
      end
      if (mac_enable) begin
        nme++;
        if (first_me < 0) first_me = c;
      end
      if (acc_valid) begin
        nv++;
        if (first_v < 0) begin
          first_v  = c;
          acc_seen = acc_out;
          ovf_seen = overflow;
        end
      end
      if (c <= busy_hi_to && !busy) busy_low++;
      if (c == restart_cyc) begin
        start = 1'b1;
        len   = 8'd1;
      end else if (c == restart_cyc + 1) begin
        start = 1'b0;
      end
    end
    check_eq({tag, ".valid_cycle"}, first_v, n + 4 - ((n == 0) ? 3 : 0));
    check_eq({tag, ".valid_pulses"}, nv, 1);
    check_eq({tag, ".acc_out"}, $signed(acc_seen), exp_acc);
    check_eq({tag, ".overflow"}, ovf_seen, exp_ovf);
    check_eq({tag, ".rd_en_cycles"}, nrd, n);
    check_eq({tag, ".mac_en_cycles"}, nme, n);
    check_eq({tag, ".first_rd_en"}, first_rd, (n == 0) ? -1 : 1);
    check_eq({tag, ".first_mac_en"}, first_me, (n == 0) ? -1 : 2);
    check_eq({tag, ".rd_addr_seq_err"}, addr_err, 0);
    check_eq({tag, ".busy_low_in_run"}, busy_low, 0);
    check_eq({tag, ".busy_after"}, busy, 0);
    check_eq({tag, ".acc_held"}, $signed(acc_out), exp_acc);
  endtask

  initial begin
    integer nv, nrd, first_v, addr_err;
    logic [15:0] acc_seen;
    rst_n = 1'b0; start = 1'b0; len = 8'd0; start2 = 1'b0; len2 = 8'd0;
    rd_a = 8'sh55; rd_b = -8'sd3;
    for (int i = 0; i < 8; i++) set_ops(i, 0, 0);
    #1;
    check_idle_zero("reset_async");
    repeat (3) @(negedge clk);
    check_idle_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);

    set_ops(0, 1, 5); set_ops(1, 2, 6); set_ops(2, 3, 7); set_ops(3, 4, 8);
    run_vec("dot4", 4, 70, 0, -1);

    // A done strobe while idle must not disturb the held result.
    @(negedge clk);
    inj_res  = 16'sh7FFF;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    check_eq("idle_done.acc_out", $signed(acc_out), 70);
    check_eq("idle_done.overflow", overflow, 0);
    check_eq("idle_done.busy", busy, 0);

    set_ops(0, -128, -128); set_ops(1, 127, -128); set_ops(2, -1, -1);
    run_vec("signed3", 3, 129, 0, -1);

    run_vec("len0", 0, 0, 0, -1);

    set_ops(0, 1, 5); set_ops(1, 2, 6); set_ops(2, 3, 7); set_ops(3, 4, 8);
    run_vec("restart_ignored", 4, 70, 0, 3);

    // Reset in cycle 3 of a len=4 run.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_reset.rd_en", rd_en, 1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("reset_midrun");
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (acc_valid) nv++;
    end
    check_eq("after_reset.valid_pulses", nv, 0);
    check_eq("after_reset.busy", busy, 0);
    set_ops(0, 2, 4); set_ops(1, 3, 5);
    run_vec("post_reset2", 2, 23, 0, -1);

    // Overflow with a 16-bit accumulator: 3 x 16384 wraps to -16384.
    first_v = -1; nv = 0; nrd = 0; addr_err = 0; acc_seen = 16'hx;
    @(negedge clk);
    start2 = 1'b1;
    len2   = 8'd3;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start2 = 1'b0;
      if (rd_en2) begin
        nrd++;
        if (rd_addr2 != 8'(c - 1)) addr_err++;
      end
      if (acc_valid2) begin
        nv++;
        if (first_v < 0) begin
          first_v  = c;
          acc_seen = acc_out2;
          check_eq("acc16.overflow", overflow2, 1);
        end
      end
    end
    check_eq("acc16.valid_cycle", first_v, 7);
    check_eq("acc16.valid_pulses", nv, 1);
    check_eq("acc16.acc_out", $signed(acc_seen), -16384);
    check_eq("acc16.rd_en_cycles", nrd, 3);
    check_eq("acc16.rd_addr_seq_err", addr_err, 0);
    check_eq("acc16.mac_a", $signed(mac_a2), -128);
    check_eq("acc16.mac_b", $signed(mac_b2), -128);
    check_eq("acc16.overflow_sticky", overflow2, 1);
    check_eq("acc16.busy_after", busy2, 0);

    // Next accepted start clears the sticky flag.
    @(negedge clk);
    start2 = 1'b1;
    len2   = 8'd0;
    @(negedge clk);
    start2 = 1'b0;
    check_eq("acc16_clr.acc_valid", acc_valid2, 1);
    check_eq("acc16_clr.overflow", overflow2, 0);
    check_eq("acc16_clr.acc_out", $signed(acc_out2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
